// File: rtl/seq_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier:
// FSM state encoding and the default operand width.
package seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_nbit.sv
// Parametrised ripple-carry adder: SUM/COUT = A + B + CIN.
// The carry chain is a local variable so the whole ripple is one procedural pass.
module adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    // Bitwise full-adder chain, LSB to MSB
    always_comb begin : ripple
        logic [WIDTH:0] carry;
        carry    = '0;
        SUM      = '0;
        carry[0] = CIN;
        for (int i = 0; i < WIDTH; i++) begin
            SUM[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
        end
        COUT = carry[WIDTH];
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Optional feature macro: SEQ_MUL_SIGNED_EN adds the SIGNED port and sign pre/post logic.
//
// Handshake: START is a request that is accepted only on an edge where the FSM is ready
// (IDLE or DONE); BUSY is high for the WIDTH RUN cycles and any START seen then is dropped;
// DONE is a single-cycle pulse marking PRODUCT valid, and PRODUCT then holds until the
// next accepted operation completes. A START during the DONE cycle chains back-to-back.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [WIDTH-1:0]   DATA1,
    input  logic [WIDTH-1:0]   DATA2,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               SIGNED,
`endif
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PRODUCT,
    output state_e             DBG_STATE
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     op_a, op_b;
    logic                 op_neg;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum_s;
    logic                 carry_s;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   final_prod;
    logic                 accept;

`ifdef SEQ_MUL_SIGNED_EN
    logic                 neg_q, neg_d;

    // Signed mode: multiply magnitudes, remember the result sign; -2^(W-1) maps to 2^(W-1)
    always_comb begin
        op_a   = DATA1;
        op_b   = DATA2;
        op_neg = 1'b0;
        if (SIGNED) begin
            if (DATA1[WIDTH-1]) op_a = -DATA1;
            if (DATA2[WIDTH-1]) op_b = -DATA2;
            op_neg = DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
        end
    end

    assign final_prod = neg_q ? -shifted : shifted;
`else
    assign op_a       = DATA1;
    assign op_b       = DATA2;
    assign op_neg     = 1'b0;
    assign final_prod = shifted;
`endif

    // Conditional partial product added into the upper accumulator half
    assign addend  = acc_lo_q[0] ? mcand_q : '0;
    assign shifted = {carry_s, sum_s, acc_lo_q[WIDTH-1:1]};
    assign accept  = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    adder_nbit #(.WIDTH(WIDTH)) u_adder (
        .A    (acc_hi_q),
        .B    (addend),
        .CIN  (1'b0),
        .SUM  (sum_s),
        .COUT (carry_s)
    );

    // Next-state, datapath update and product capture
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
`ifdef SEQ_MUL_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d  = ST_RUN;
                    mcand_d  = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                    count_d  = '0;
`ifdef SEQ_MUL_SIGNED_EN
                    neg_d    = op_neg;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                {acc_hi_d, acc_lo_d} = shifted;
                count_d              = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    product_d = final_prod;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight multiply
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign BUSY      = (state_q == ST_RUN);
    assign DONE      = (state_q == ST_DONE);
    assign PRODUCT   = product_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: an 8-bit instance for the main scenarios and a 16-bit
// instance for the wide case; expected products come from plain integer multiplication.
module tb_seq_multiplier;
    import seq_mul_pkg::*;

    // ---------------- clock / reset ----------------
    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    logic        START = 1'b0;
    logic [7:0]  DATA1 = '0;
    logic [7:0]  DATA2 = '0;
    logic        sgn   = 1'b0;
    logic        BUSY, DONE;
    logic [15:0] PRODUCT;
    state_e      dbg_state;

    logic        start16 = 1'b0;
    logic [15:0] d1_16   = '0;
    logic [15:0] d2_16   = '0;
    logic        busy16, done16;
    logic [31:0] product16;
    state_e      dbg_state16;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    seq_multiplier #(.WIDTH(8)) u_dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
`ifdef SEQ_MUL_SIGNED_EN
        .SIGNED    (sgn),
`endif
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PRODUCT   (PRODUCT),
        .DBG_STATE (dbg_state)
    );

    seq_multiplier #(.WIDTH(16)) u_dut16 (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (start16),
        .DATA1     (d1_16),
        .DATA2     (d2_16),
`ifdef SEQ_MUL_SIGNED_EN
        .SIGNED    (1'b0),
`endif
        .BUSY      (busy16),
        .DONE      (done16),
        .PRODUCT   (product16),
        .DBG_STATE (dbg_state16)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        return 16'(x * y);
    endfunction

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [15:0] prod, output int done_cyc, output int busy_cyc,
                         output int hold_err);
        logic [15:0] held;
        held  = PRODUCT;
        START = 1'b1;
        DATA1 = a;
        DATA2 = b;
        sgn   = s;
        @(negedge CLK);
        START = 1'b0;
        DATA1 = 8'($urandom);
        DATA2 = 8'($urandom);
        sgn   = 1'($urandom);
        done_cyc = 0;
        busy_cyc = 0;
        hold_err = 0;
        for (int c = 1; c <= 40; c++) begin
            if (DONE) begin
                done_cyc = c;
                break;
            end
            if (BUSY) busy_cyc++;
            if (PRODUCT !== held) hold_err++;
            @(negedge CLK);
        end
        prod = PRODUCT;
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] prod, output int done_cyc);
        start16 = 1'b1;
        d1_16   = a;
        d2_16   = b;
        @(negedge CLK);
        start16 = 1'b0;
        d1_16   = 16'($urandom);
        d2_16   = 16'($urandom);
        done_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done16) begin
                done_cyc = c;
                break;
            end
            @(negedge CLK);
        end
        prod = product16;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        #2;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", DONE); end
        checks++; if (PRODUCT !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", PRODUCT); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL idle_done got=%0b exp=0", DONE); end
        checks++; if (PRODUCT !== 16'h0000) begin errors++; $display("FAIL idle_product got=%h exp=0000", PRODUCT); end
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int dc, bc, he;
        do_op(8'd13, 8'd11, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'd143) begin errors++; $display("FAIL basic_product got=%0d exp=143", p); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=9", dc); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        checks++; if (he !== 0) begin errors++; $display("FAIL basic_product_hold got=%0d exp=0", he); end
        @(negedge CLK);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%0b exp=0", DONE); end
        checks++; if (PRODUCT !== 16'd143) begin errors++; $display("FAIL basic_product_kept got=%0d exp=143", PRODUCT); end
    endtask

    task automatic test_edges();
        logic [15:0] p;
        int dc, bc, he;
        @(negedge CLK);
        do_op(8'hFF, 8'hFF, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL max_product got=%h exp=fe01", p); end
        @(negedge CLK);
        do_op(8'h00, 8'hA5, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_a_product got=%h exp=0000", p); end
        do_op(8'hA5, 8'h00, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_b_product got=%h exp=0000", p); end
        @(negedge CLK);
    endtask

    task automatic test_start_held();
        int dc;
        dc    = 0;
        START = 1'b1;
        DATA1 = 8'd7;
        DATA2 = 8'd9;
        sgn   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            DATA1 = 8'($urandom);
            DATA2 = 8'($urandom);
            if (DONE) begin
                dc = c;
                break;
            end
        end
        START = 1'b0;
        checks++; if (dc !== 9) begin errors++; $display("FAIL held_done_cycle got=%0d exp=9", dc); end
        checks++; if (PRODUCT !== 16'd63) begin errors++; $display("FAIL held_product got=%0d exp=63", PRODUCT); end
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL held_no_restart got=%0b exp=0", BUSY); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int dc, bc, he;
        do_op(8'd12, 8'd10, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'd120) begin errors++; $display("FAIL b2b_first got=%0d exp=120", p); end
        do_op(8'd2, 8'd3, 1'b0, p, dc, bc, he);
        checks++; if (dc !== 9) begin errors++; $display("FAIL b2b_spacing got=%0d exp=9", dc); end
        checks++; if (p !== 16'd6) begin errors++; $display("FAIL b2b_second got=%0d exp=6", p); end
        checks++; if (he !== 0) begin errors++; $display("FAIL b2b_hold got=%0d exp=0", he); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int dc, bc, he, done_seen;
        do_op(8'd50, 8'd5, 1'b0, p, dc, bc, he);
        @(negedge CLK);
        START = 1'b1;
        DATA1 = 8'd77;
        DATA2 = 8'd33;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%0b exp=0", BUSY); end
        checks++; if (PRODUCT !== 16'h0000) begin errors++; $display("FAIL midreset_product got=%h exp=0000", PRODUCT); end
        @(negedge CLK);
        RESET_N = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE || BUSY) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", done_seen); end
        do_op(8'd9, 8'd9, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'd81) begin errors++; $display("FAIL midreset_next_op got=%0d exp=81", p); end
        @(negedge CLK);
    endtask

    task automatic test_random();
        logic [15:0] p, e;
        logic [7:0]  a, b;
        logic        s;
        int dc, bc, he;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            exp_q.push_back(ref_mul(a, b, s));
            do_op(a, b, s, p, dc, bc, he);
            e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL rand_product a=%h b=%h s=%0b got=%h exp=%h", a, b, s, p, e); end
            checks++; if (dc !== 9) begin errors++; $display("FAIL rand_latency got=%0d exp=9", dc); end
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
    endtask

`ifdef SEQ_MUL_SIGNED_EN
    task automatic test_signed();
        logic [15:0] p;
        int dc, bc, he;
        do_op(8'hFD, 8'h05, 1'b1, p, dc, bc, he);
        checks++; if (p !== 16'hFFF1) begin errors++; $display("FAIL signed_m3x5 got=%h exp=fff1", p); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL signed_latency got=%0d exp=9", dc); end
        do_op(8'h80, 8'h80, 1'b1, p, dc, bc, he);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL signed_min_sq got=%h exp=4000", p); end
        do_op(8'hFF, 8'h00, 1'b1, p, dc, bc, he);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL signed_m1x0 got=%h exp=0000", p); end
        do_op(8'hFD, 8'h05, 1'b0, p, dc, bc, he);
        checks++; if (p !== 16'h04F1) begin errors++; $display("FAIL unsigned_fdx05 got=%h exp=04f1", p); end
        @(negedge CLK);
    endtask
`endif

    task automatic test_wide16();
        logic [31:0] p, e;
        logic [15:0] a, b;
        int dc;
        do_op16(16'hFFFF, 16'hFFFF, p, dc);
        checks++; if (p !== 32'hFFFE0001) begin errors++; $display("FAIL wide_max got=%h exp=fffe0001", p); end
        checks++; if (dc !== 17) begin errors++; $display("FAIL wide_latency got=%0d exp=17", dc); end
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            e = 32'(longint'(a) * longint'(b));
            @(negedge CLK);
            do_op16(a, b, p, dc);
            checks++; if (p !== e) begin errors++; $display("FAIL wide_rand a=%h b=%h got=%h exp=%h", a, b, p, e); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_MUL_SIGNED_EN
        test_signed();
`endif
        test_random();
        test_wide16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
